// File: rtl/picorv32_axi_bridge.sv
// PicoRV32 native memory interface to AXI4-Lite master bridge.
// One registered AXI transaction per in-window request, with response checking, watchdog and sticky error capture.
module picorv32_axi_bridge #(
  parameter int unsigned C_AXI_ADDR_WIDTH = 16,
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR        = 32'h8000_0000,
  parameter logic [31:0] WINDOW_SIZE      = 32'h0001_0000,
  parameter int unsigned TIMEOUT_CYCLES   = 255,
  parameter logic [31:0] ERR_RDATA        = 32'hDEAD_BEEF
) (
  input  logic                        M_AXI_ACLK,
  input  logic                        M_AXI_ARESETN,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]                  M_AXI_AWPROT,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  output logic [31:0]                 M_AXI_WDATA,
  output logic [3:0]                  M_AXI_WSTRB,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                  M_AXI_ARPROT,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,
  input  logic [31:0]                 M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        mem_valid,
  input  logic                        mem_instr,
  input  logic [31:0]                 mem_addr,
  input  logic [31:0]                 mem_wdata,
  input  logic [3:0]                  mem_wstrb,
  output logic                        mem_ready,
  output logic [31:0]                 mem_rdata,
  output logic                        win_hit,
  input  logic                        err_clear,
  output logic [1:0]                  err_status,
  output logic [31:0]                 err_addr,
  output logic                        irq_err
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WIN_MASK = ~(WINDOW_SIZE - 32'd1);

  if (C_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("picorv32_axi_bridge: C_AXI_DATA_WIDTH must be 32");
  end
  if ((C_AXI_ADDR_WIDTH < 1) || (C_AXI_ADDR_WIDTH > 32)) begin : g_bad_addr_width
    $error("picorv32_axi_bridge: C_AXI_ADDR_WIDTH must be 1..32");
  end
  if ((WINDOW_SIZE == 32'd0) || ((WINDOW_SIZE & (WINDOW_SIZE - 32'd1)) != 32'd0)) begin : g_bad_window
    $error("picorv32_axi_bridge: WINDOW_SIZE must be a power of two");
  end
  if ((BASE_ADDR & ~WIN_MASK) != 32'd0) begin : g_bad_base
    $error("picorv32_axi_bridge: BASE_ADDR must be aligned to WINDOW_SIZE");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_READ, S_RRESP, S_DONE
  } state_t;

  state_t                      r_state,      w_state_next;
  logic [C_AXI_ADDR_WIDTH-1:0] r_addr,       w_addr_next;
  logic [31:0]                 r_mem_addr,   w_mem_addr_next;
  logic [31:0]                 r_wdata,      w_wdata_next;
  logic [3:0]                  r_wstrb,      w_wstrb_next;
  logic [2:0]                  r_prot,       w_prot_next;
  logic                        r_awvalid,    w_awvalid_next;
  logic                        r_wvalid,     w_wvalid_next;
  logic                        r_bready,     w_bready_next;
  logic                        r_arvalid,    w_arvalid_next;
  logic                        r_rready,     w_rready_next;
  logic                        r_mem_ready,  w_mem_ready_next;
  logic [31:0]                 r_mem_rdata,  w_mem_rdata_next;
  logic [1:0]                  r_err_status, w_err_status_next;
  logic [31:0]                 r_err_addr,   w_err_addr_next;
  logic [WD_W-1:0]             r_wdog,       w_wdog_next;

  logic       w_hit;
  logic       w_busy;
  logic       w_aw_done;
  logic       w_w_done;
  logic       w_err_set;
  logic [1:0] w_err_code;

  assign w_hit   = ((mem_addr & WIN_MASK) == BASE_ADDR);
  assign win_hit = mem_valid & w_hit;
  assign w_busy  = (r_state == S_WRITE) || (r_state == S_WRESP) ||
                   (r_state == S_READ)  || (r_state == S_RRESP);

  // A channel is finished once its VALID has dropped or is being accepted now.
  assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
  assign w_w_done  = !r_wvalid  || M_AXI_WREADY;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_mem_addr   <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_prot       <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_mem_ready  <= 1'b0;
      r_mem_rdata  <= '0;
      r_err_status <= '0;
      r_err_addr   <= '0;
      r_wdog       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_addr       <= w_addr_next;
      r_mem_addr   <= w_mem_addr_next;
      r_wdata      <= w_wdata_next;
      r_wstrb      <= w_wstrb_next;
      r_prot       <= w_prot_next;
      r_awvalid    <= w_awvalid_next;
      r_wvalid     <= w_wvalid_next;
      r_bready     <= w_bready_next;
      r_arvalid    <= w_arvalid_next;
      r_rready     <= w_rready_next;
      r_mem_ready  <= w_mem_ready_next;
      r_mem_rdata  <= w_mem_rdata_next;
      r_err_status <= w_err_status_next;
      r_err_addr   <= w_err_addr_next;
      r_wdog       <= w_wdog_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_addr_next       = r_addr;
    w_mem_addr_next   = r_mem_addr;
    w_wdata_next      = r_wdata;
    w_wstrb_next      = r_wstrb;
    w_prot_next       = r_prot;
    w_awvalid_next    = r_awvalid;
    w_wvalid_next     = r_wvalid;
    w_bready_next     = r_bready;
    w_arvalid_next    = r_arvalid;
    w_rready_next     = r_rready;
    w_mem_ready_next  = 1'b0;
    w_mem_rdata_next  = r_mem_rdata;
    w_err_status_next = r_err_status;
    w_err_addr_next   = r_err_addr;
    w_wdog_next       = r_wdog;
    w_err_set         = 1'b0;
    w_err_code        = 2'b00;

    case (r_state)
      S_IDLE: begin
        if (mem_valid && w_hit) begin
          w_addr_next     = mem_addr[C_AXI_ADDR_WIDTH-1:0];
          w_mem_addr_next = mem_addr;
          w_wdata_next    = mem_wdata;
          w_wstrb_next    = mem_wstrb;
          w_prot_next     = mem_instr ? 3'b100 : 3'b000;
          if (|mem_wstrb) begin
            w_state_next   = S_WRITE;
            w_awvalid_next = 1'b1;
            w_wvalid_next  = 1'b1;
          end else begin
            w_state_next   = S_READ;
            w_arvalid_next = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (r_awvalid && M_AXI_AWREADY) w_awvalid_next = 1'b0;
        if (r_wvalid && M_AXI_WREADY)   w_wvalid_next  = 1'b0;
        if (w_aw_done && w_w_done) begin
          w_state_next  = S_WRESP;
          w_bready_next = 1'b1;
        end
      end
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          w_state_next     = S_DONE;
          w_bready_next    = 1'b0;
          w_mem_ready_next = 1'b1;
          w_mem_rdata_next = '0;
          w_err_set        = M_AXI_BRESP[1];
          w_err_code       = {~M_AXI_BRESP[0], M_AXI_BRESP[0]};
        end
      end
      S_READ: begin
        if (M_AXI_ARREADY) begin
          w_state_next   = S_RRESP;
          w_arvalid_next = 1'b0;
          w_rready_next  = 1'b1;
        end
      end
      S_RRESP: begin
        if (M_AXI_RVALID) begin
          w_state_next     = S_DONE;
          w_rready_next    = 1'b0;
          w_mem_ready_next = 1'b1;
          w_mem_rdata_next = M_AXI_RRESP[1] ? ERR_RDATA : M_AXI_RDATA;
          w_err_set        = M_AXI_RRESP[1];
          w_err_code       = {~M_AXI_RRESP[0], M_AXI_RRESP[0]};
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // A response arriving on the last allowed cycle wins over the timeout.
    if (w_busy) begin
      if (WD_EN && (r_wdog == WD_LAST) && (w_state_next != S_DONE)) begin
        w_state_next     = S_DONE;
        w_awvalid_next   = 1'b0;
        w_wvalid_next    = 1'b0;
        w_bready_next    = 1'b0;
        w_arvalid_next   = 1'b0;
        w_rready_next    = 1'b0;
        w_mem_ready_next = 1'b1;
        w_mem_rdata_next = ERR_RDATA;
        w_err_set        = 1'b1;
        w_err_code       = 2'b11;
        w_wdog_next      = '0;
      end else begin
        w_wdog_next = r_wdog + 1'b1;
      end
    end else begin
      w_wdog_next = '0;
    end

    // A new error in the same cycle as err_clear is kept rather than lost.
    if (w_err_set && ((r_err_status == 2'b00) || err_clear)) begin
      w_err_status_next = w_err_code;
      w_err_addr_next   = r_mem_addr;
    end else if (err_clear) begin
      w_err_status_next = 2'b00;
      w_err_addr_next   = '0;
    end
  end

  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = r_prot;
  assign M_AXI_RREADY  = r_rready;
  assign mem_ready     = r_mem_ready;
  assign mem_rdata     = r_mem_rdata;
  assign err_status    = r_err_status;
  assign err_addr      = r_err_addr;
  assign irq_err       = |r_err_status;

endmodule
